// File: rtl/adder_pipe_nbit.sv
// Chunked ripple-carry adder/subtractor pipeline: each stage adds one CHUNK_WIDTH slice
// and registers its carry for the next stage, with valid/ready flow control.

module adder_pipe_nbit_chk #(
  parameter int BIT_WIDTH = 16
) (
  input logic                 clk,
  input logic                 n_rst,
  input logic                 in_valid,
  input logic [BIT_WIDTH-1:0] a,
  input logic [BIT_WIDTH-1:0] b,
  input logic                 carry_in,
  input logic                 sub
);
  // Operands presented as valid must be fully known.
  a_known_inputs: assert property (@(posedge clk) disable iff (!n_rst)
    in_valid |-> !$isunknown({a, b, carry_in, sub}));
endmodule

module adder_pipe_nbit #(
  parameter int BIT_WIDTH   = 16,
  parameter int CHUNK_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 carry_in,
  input  logic                 sub,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BIT_WIDTH-1:0] sum,
  output logic                 overflow,
  output logic                 signed_ovf,
  output logic                 out_valid,
  input  logic                 out_ready
);
  localparam int NUM_STAGES = BIT_WIDTH / CHUNK_WIDTH;
  localparam int LAST       = NUM_STAGES - 1;
  localparam int OPD        = (NUM_STAGES > 1) ? NUM_STAGES - 1 : 1;

  function automatic logic [CHUNK_WIDTH:0] add_chunk(
    input logic [CHUNK_WIDTH-1:0] x,
    input logic [CHUNK_WIDTH-1:0] y,
    input logic                   ci
  );
    add_chunk = {1'b0, x} + {1'b0, y} + {{CHUNK_WIDTH{1'b0}}, ci};
  endfunction

  // Operands only need to travel to the stages that still consume them.
  logic [OPD-1:0][BIT_WIDTH-1:0]        a_r;
  logic [OPD-1:0][BIT_WIDTH-1:0]        b_r;
  logic [NUM_STAGES-1:0][BIT_WIDTH-1:0] sum_r;
  logic [NUM_STAGES-1:0]                carry_r;
  logic [NUM_STAGES-1:0]                valid_r;
  logic                                 sovf_r;

  logic [NUM_STAGES-1:0][BIT_WIDTH-1:0] a_in_s;
  logic [NUM_STAGES-1:0][BIT_WIDTH-1:0] b_in_s;
  logic [NUM_STAGES-1:0][BIT_WIDTH-1:0] s_in_s;
  logic [NUM_STAGES-1:0]                c_in_s;
  logic [NUM_STAGES-1:0]                v_in_s;
  logic [NUM_STAGES-1:0][BIT_WIDTH-1:0] sum_nxt_s;
  logic [NUM_STAGES-1:0]                carry_nxt_s;
  logic                                 sovf_nxt_s;
  logic                                 adv_s;

  // Whole pipeline advances unless a finished result is being held back.
  always_comb begin
    adv_s = !(valid_r[LAST] && !out_ready);
  end

  assign in_ready   = adv_s;
  assign sum        = sum_r[LAST];
  assign overflow   = carry_r[LAST];
  assign signed_ovf = sovf_r;
  assign out_valid  = valid_r[LAST];

  // Stage inputs and per-stage chunk additions; subtraction folds in at stage 0.
  always_comb begin
    a_in_s      = '0;
    b_in_s      = '0;
    s_in_s      = '0;
    c_in_s      = '0;
    v_in_s      = '0;
    sum_nxt_s   = '0;
    carry_nxt_s = '0;
    a_in_s[0]   = a;
    b_in_s[0]   = sub ? ~b : b;
    c_in_s[0]   = sub ? 1'b1 : carry_in;
    v_in_s[0]   = in_valid;
    for (int k = 1; k < NUM_STAGES; k++) begin
      a_in_s[k] = a_r[k-1];
      b_in_s[k] = b_r[k-1];
      s_in_s[k] = sum_r[k-1];
      c_in_s[k] = carry_r[k-1];
      v_in_s[k] = valid_r[k-1];
    end
    for (int k = 0; k < NUM_STAGES; k++) begin
      sum_nxt_s[k] = s_in_s[k];
      {carry_nxt_s[k], sum_nxt_s[k][k*CHUNK_WIDTH +: CHUNK_WIDTH]} =
        add_chunk(a_in_s[k][k*CHUNK_WIDTH +: CHUNK_WIDTH],
                  b_in_s[k][k*CHUNK_WIDTH +: CHUNK_WIDTH], c_in_s[k]);
    end
    sovf_nxt_s = (a_in_s[LAST][BIT_WIDTH-1] == b_in_s[LAST][BIT_WIDTH-1]) &&
                 (sum_nxt_s[LAST][BIT_WIDTH-1] != a_in_s[LAST][BIT_WIDTH-1]);
  end

  // Stage registers: cleared by reset, loaded together on advance, held on stall.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= '0;
      valid_r <= '0;
      sovf_r  <= 1'b0;
    end else if (adv_s) begin
      sum_r   <= sum_nxt_s;
      carry_r <= carry_nxt_s;
      valid_r <= v_in_s;
      sovf_r  <= sovf_nxt_s;
      for (int k = 0; k < NUM_STAGES - 1; k++) begin
        a_r[k] <= a_in_s[k];
        b_r[k] <= b_in_s[k];
      end
    end
  end

`ifndef SYNTHESIS
  adder_pipe_nbit_chk #(.BIT_WIDTH(BIT_WIDTH)) u_chk (
    .clk      (clk),
    .n_rst    (n_rst),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .carry_in (carry_in),
    .sub      (sub)
  );
`endif

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Scoreboard bench for adder_pipe_nbit: golden full-width model results are queued on
// transfer-in and compared in order on transfer-out.

module tb_adder_pipe_nbit;
  localparam int BW = 16;
  localparam int CW = 4;
  localparam int NS = BW / CW;

  logic          clk;
  logic          n_rst;
  logic [BW-1:0] a;
  logic [BW-1:0] b;
  logic          carry_in;
  logic          sub;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] sum;
  logic          overflow;
  logic          signed_ovf;
  logic          out_valid;
  logic          out_ready;

  typedef struct {
    logic [BW-1:0] s;
    logic          o;
    logic          so;
    bit            lat;
    int            cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   ncyc     = 0;
  int   tcyc     = 0;
  int   st_lo    = 0;
  int   st_hi    = -1;
  bit   rnd_or   = 1'b0;
  bit   lat_mode = 1'b0;

  adder_pipe_nbit #(.BIT_WIDTH(BW), .CHUNK_WIDTH(CW)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .a          (a),
    .b          (b),
    .carry_in   (carry_in),
    .sub        (sub),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sum        (sum),
    .overflow   (overflow),
    .signed_ovf (signed_ovf),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t golden(input logic [BW-1:0] ta, input logic [BW-1:0] tb,
                                  input logic tci, input logic tsub);
    logic [BW-1:0] be;
    logic          ce;
    logic [BW:0]   full;
    exp_t          e;
    be    = tsub ? ~tb : tb;
    ce    = tsub ? 1'b1 : tci;
    full  = {1'b0, ta} + {1'b0, be} + {{BW{1'b0}}, ce};
    e.s   = full[BW-1:0];
    e.o   = full[BW];
    e.so  = (ta[BW-1] == be[BW-1]) && (full[BW-1] != ta[BW-1]);
    e.lat = lat_mode;
    e.cyc = ncyc;
    return e;
  endfunction

  // Monitor: inputs and outputs are stable at the falling edge and describe the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (n_rst) begin
      check_eq("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_eq("sum", 32'(sum), 32'(e.s));
          check_eq("overflow", 32'(overflow), 32'(e.o));
          check_eq("signed_ovf", 32'(signed_ovf), 32'(e.so));
          if (e.lat) check_eq("latency", 32'(ncyc - e.cyc), 32'(NS));
        end
      end else if (out_valid && sb_q.size() > 0) begin
        check_eq("stall_hold", 32'(sum), 32'(sb_q[0].s));
      end
      if (in_valid && in_ready) sb_q.push_back(golden(a, b, carry_in, sub));
    end
  end

  task automatic tick(output bit acc);
    tcyc++;
    if (rnd_or) out_ready = ($urandom_range(0, 9) < 7);
    else        out_ready = !(tcyc >= st_lo && tcyc <= st_hi);
    #1;
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [BW-1:0] ta, input logic [BW-1:0] tb,
                      input logic tci, input logic tsub);
    bit acc;
    int w;
    a = ta; b = tb; carry_in = tci; sub = tsub; in_valid = 1'b1;
    w = 0;
    do begin
      tick(acc);
      w++;
    end while (!acc && w < 100);
    check_eq("send_accept", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int w;
    in_valid = 1'b0;
    w = 0;
    while ((sb_q.size() > 0 || out_valid) && w < 300) begin
      tick(acc);
      w++;
    end
    check_eq("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  logic [BW-1:0] da [8] = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h1234, 16'hFFFF, 16'h8000};
  logic [BW-1:0] db [8] = '{16'h0001, 16'h0000, 16'h0001, 16'h0007, 16'h0001, 16'h4321, 16'hFFFF, 16'h8000};
  logic          dc [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic          ds [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    bit acc;
    int w;
    int n;
    int cycles;
    n_rst = 1'b0; a = '0; b = '0; carry_in = 1'b0; sub = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;

    // Reset state before any clock edge.
    #2;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_sum", 32'(sum), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_signed_ovf", 32'(signed_ovf), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    n_rst = 1'b1;

    // Directed arithmetic, back-to-back, first one on the first edge after reset.
    lat_mode = 1'b1;
    for (int i = 0; i < 8; i++) send(da[i], db[i], dc[i], ds[i]);
    drain();

    // Eight consecutive ops with downstream stalled in cycles 5..7.
    lat_mode = 1'b0;
    tcyc = 0; st_lo = 5; st_hi = 7;
    for (int i = 1; i <= 8; i++) send(16'(i), 16'(i), 1'b0, 1'b0);
    drain();
    st_hi = -1;

    // Reset while three ops are in flight and the first result is held.
    tcyc = 0; st_lo = 1; st_hi = 1000;
    send(16'h0100, 16'h0011, 1'b0, 1'b0);
    send(16'h0200, 16'h0022, 1'b0, 1'b0);
    send(16'h0300, 16'h0033, 1'b1, 1'b0);
    w = 0;
    while (!out_valid && w < 10) begin
      tick(acc);
      w++;
    end
    check_eq("mid_out_valid", 32'(out_valid), 32'd1);
    #2;
    n_rst = 1'b0;
    sb_q.delete();
    #1;
    check_eq("async_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("async_rst_sum", 32'(sum), 32'd0);
    check_eq("async_rst_overflow", 32'(overflow), 32'd0);
    check_eq("async_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    st_hi = -1;
    lat_mode = 1'b1;
    send(16'h0001, 16'h0001, 1'b0, 1'b0);
    drain();

    // Random traffic with random valid and backpressure.
    lat_mode = 1'b0;
    rnd_or = 1'b1;
    n = 0;
    cycles = 0;
    while (n < 10000 && cycles < 60000) begin
      in_valid = ($urandom_range(0, 9) < 7);
      a        = 16'($urandom);
      b        = 16'($urandom);
      carry_in = 1'($urandom_range(0, 1));
      sub      = 1'($urandom_range(0, 1));
      tick(acc);
      if (acc) n++;
      cycles++;
    end
    check_eq("random_ops", 32'(n), 32'd10000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adder_pipe_nbit.md
ADDER_PIPE_NBIT -- requirements
Module: adder_pipe_nbit

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 16, operand/sum width; legal values are multiples of CHUNK_WIDTH, >= CHUNK_WIDTH.
REQ-002 SHALL have parameter CHUNK_WIDTH, default 4, bits added per pipeline stage; NUM_STAGES = BIT_WIDTH/CHUNK_WIDTH (derived, not overridable).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 n_rst  input  1  asynchronous, active-low reset.
REQ-005 a  input  BIT_WIDTH  operand A.
REQ-006 b  input  BIT_WIDTH  operand B.
REQ-007 carry_in  input  1  carry into bit 0 (ignored when sub=1).
REQ-008 sub  input  1  0: a+b+carry_in; 1: a-b (a + ~b + 1).
REQ-009 in_valid  input  1  a/b/carry_in/sub valid this cycle.
REQ-010 in_ready  output  1  block accepts an operation this cycle.
REQ-011 sum  output  BIT_WIDTH  registered result.
REQ-012 overflow  output  1  carry out of MSB (unsigned overflow for add; 1 = no borrow for sub).
REQ-013 signed_ovf  output  1  two's-complement overflow of the result.
REQ-014 out_valid  output  1  sum/overflow/signed_ovf valid.
REQ-015 out_ready  input  1  downstream accepts the result.

Function
REQ-016 Transfer-in SHALL occur on a rising edge where in_valid=1 and in_ready=1; transfer-out where out_valid=1 and out_ready=1.
REQ-017 Pipeline SHALL have NUM_STAGES register stages; stage k adds chunk k (bits k*CHUNK_WIDTH .. (k+1)*CHUNK_WIDTH-1) using the carry registered by stage k-1; unadded upper operand chunks and completed lower sum chunks SHALL be carried along in stage registers.
REQ-018 Latency SHALL be exactly NUM_STAGES cycles from transfer-in to out_valid=1 when no stall occurs; throughput one operation per cycle.
REQ-019 Each stage SHALL hold a valid bit; out_valid equals the last stage's valid bit.
REQ-020 Stall: pipeline advance enable = !(out_valid && !out_ready); when enable=0 every stage register, including valid bits, SHALL hold.
REQ-021 in_ready SHALL equal the advance enable (combinational from out_valid, out_ready); in_ready SHALL NOT depend on in_valid.
REQ-022 Bubbles: when enable=1 and no transfer-in, stage 0 valid SHALL load 0; bubbles SHALL propagate and SHALL NOT raise out_valid.
REQ-023 Simultaneous transfer-in and transfer-out on a full pipeline SHALL both complete with no loss or duplication.
REQ-024 sub=1: stage 0 SHALL use ~b chunk and carry 1; sub mode SHALL be captured at transfer-in and travel with the operation.
REQ-025 sum SHALL be (a + b + carry_in) mod 2^BIT_WIDTH, or (a - b) mod 2^BIT_WIDTH when sub=1.
REQ-026 overflow SHALL be bit BIT_WIDTH of the full-width add of a, (sub ? ~b : b), and (sub ? 1 : carry_in).
REQ-027 signed_ovf SHALL be 1 iff the MSBs of both effective addends are equal and differ from sum MSB.
REQ-028 Results SHALL emerge in acceptance order; outputs SHALL stay stable while out_valid=1 and out_ready=0.
REQ-029 Inputs X/Z while in_valid=1 SHALL be flagged by a simulation-only assertion; assertions SHALL not affect synthesis.

Reset
REQ-030 n_rst=0 SHALL immediately, without clk, clear all valid bits, sum=0, overflow=0, signed_ovf=0, out_valid=0.
REQ-031 in_ready SHALL be 1 during and after reset (out_valid=0).
REQ-032 Reset mid-operation SHALL discard all in-flight operations; none SHALL appear after n_rst returns to 1.
REQ-033 First transfer-in SHALL be possible on the first rising edge after n_rst deasserts.

Verification (BIT_WIDTH=16, CHUNK_WIDTH=4, NUM_STAGES=4)
REQ-034 Add: a=16'h00FF, b=16'h0001, carry_in=0, out_ready=1 -> 4 cycles later sum=16'h0100, overflow=0, signed_ovf=0, out_valid=1 one cycle.
REQ-035 Wrap/overflow: a=16'hFFFF, b=16'h0000, carry_in=1 -> sum=16'h0000, overflow=1; a=16'h7FFF, b=16'h0001 -> sum=16'h8000, signed_ovf=1.
REQ-036 Subtract: a=16'h0005, b=16'h0007, sub=1 -> sum=16'hFFFE, overflow=0; a=16'h8000, b=16'h0001, sub=1 -> sum=16'h7FFF, signed_ovf=1.
REQ-037 Back-to-back/stall: 8 consecutive ops a=i, b=i (i=1..8) with out_ready low for cycles 5-7 -> in_ready=0 while stalled, results 2,4,...,16 in order, none lost or repeated.
REQ-038 Reset mid-flight: 3 ops accepted, n_rst pulsed low before any output -> out_valid=0 immediately, no result from those ops afterwards; new op a=1,b=1 -> sum=2 after 4 cycles.
REQ-039 Random: 10,000 random a/b/carry_in/sub with random in_valid/out_ready -> every output matches REQ-025..027 golden model in order.
